// File: rtl/check_seq_ctrl_pkg.sv
// Shared state encoding and default widths for the sequence-detector sequencer.
package check_seq_ctrl_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_SHIFT = ST_SHIFT,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_LOOP_W  = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_HIT_LAT = 1;
endpackage

// File: rtl/check_seq_ctrl_sat_counter.sv
// Saturating event counter; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc_i) begin
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            // sticky once the count reaches all-ones
            if (count_d == '1) sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;
endmodule

// File: rtl/check_seq_ctrl.sv
// Accepts a word, clears the detector, shifts the word LSB-first for N passes
// and counts detector hits with a saturating counter.
module check_seq_ctrl
    import check_seq_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LOOP_W  = DEF_LOOP_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HIT_LAT = DEF_HIT_LAT
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LOOP_W-1:0] in_loops,
    input  logic              abort,
    output logic              det_din,
    output logic              det_clr,
    input  logic              det_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic              hit_sat
);
    localparam int BIT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DRAIN_LAST = (HIT_LAT > 0) ? HIT_LAT - 1 : 0;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [1:0]        drain_q, drain_d;
    logic              cnt_clr, cnt_inc;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_sat;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        loops_d = loops_q;
        bit_d   = bit_q;
        drain_d = drain_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    loops_d = (in_loops == '0) ? LOOP_W'(1) : in_loops;
                    bit_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                drain_d = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d = {shreg_q[0], shreg_q[DATA_W-1:1]};
                cnt_inc = det_hit;
                if (bit_q == BIT_W'(DATA_W - 1)) begin
                    bit_d = '0;
                    if (loops_q == LOOP_W'(1))
                        state_d = (HIT_LAT == 0) ? S_DONE : S_DRAIN;
                    else
                        loops_d = loops_q - LOOP_W'(1);
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end
            S_DRAIN: begin
                // catches hits for the last bits still in the detector pipeline
                cnt_inc = det_hit;
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(DRAIN_LAST)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q == S_LOAD || state_q == S_SHIFT || state_q == S_DRAIN))
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            loops_q <= '0;
            bit_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            loops_q <= loops_d;
            bit_q   <= bit_d;
            drain_q <= drain_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk     (clk),
        .rst_    (rst_),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .count_o (cnt),
        .sat_o   (cnt_sat)
    );

    // outputs are forced low while reset is asserted, before the edge lands
    assign in_ready  = rst_ && (state_q == S_IDLE);
    assign busy      = rst_ && (state_q != S_IDLE);
    assign done      = rst_ && (state_q == S_DONE);
    assign det_clr   = rst_ && (state_q == S_LOAD);
    assign det_din   = rst_ && (state_q == S_SHIFT) && shreg_q[0];
    assign hit_count = rst_ ? cnt : '0;
    assign hit_sat   = rst_ && cnt_sat;
endmodule

// File: doc/check_seq_ctrl.md
Name: check_seq_ctrl

Overview:
Sequencer for a serial sequence-detector datapath (din/find_out style, e.g. check_sm). Accepts a parallel word through a valid/ready handshake, clears the detector, then shifts the word out LSB-first for a programmable number of passes, rotating it so each pass repeats the word. It counts the detector's hit pulses and reports a saturating hit count with a one-cycle done pulse. The block sits between a host/bench word source and one detector instance.

Parameters:
DATA_W, 8, word width / bits shifted per pass (>=2)
LOOP_W, 4, width of pass-count input
CNT_W, 8, width of hit counter
HIT_LAT, 1, cycles from det_din bit to its det_hit response (0..3)

Ports:
clk  in  1  system clock, all state on rising edge
rst_  in  1  synchronous reset, active-low
in_valid  in  1  word offered
in_ready  out  1  block can accept a word
in_data  in  DATA_W  word to shift, bit 0 first
in_loops  in  LOOP_W  number of passes; 0 treated as 1
abort  in  1  cancel the current run
det_din  out  1  serial bit to detector din
det_clr  out  1  detector clear pulse
det_hit  in  1  detector find_out
busy  out  1  run in progress (state != IDLE)
done  out  1  one-cycle pulse, run finished normally
hit_count  out  CNT_W  hits in last/current run
hit_sat  out  1  sticky: hit_count saturated this run

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clk, reset port is rst_.
- Reset (rst_=0 at a clk edge): state=IDLE; hit_count=0, hit_sat=0, done=0, det_clr=0, shift reg=0. Outputs are 0 while rst_ is low, including in_ready. Reset mid-run abandons the run with no done.
- States: IDLE, LOAD, SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid: latch in_data into shift reg, loops_left=max(in_loops,1), bit_cnt=0, hit_count=0, hit_sat=0, go to LOAD. abort is ignored in IDLE.
- LOAD (1 cycle): det_clr=1, det_din=0; go to SHIFT.
- SHIFT: det_din=shreg[0] (combinational from register). Each cycle shreg rotates right (bit 0 to MSB) and bit_cnt increments.
  - At bit_cnt==DATA_W-1: bit_cnt=0. If loops_left==1, go to DRAIN (or to DONE if HIT_LAT=0); otherwise decrement loops_left.
  - Total SHIFT cycles = DATA_W*loops.
- DRAIN: HIT_LAT cycles, det_din=0; then go to DONE.
- DONE (1 cycle): done=1, in_ready=0; next state IDLE. in_valid held through DONE is accepted in the following IDLE cycle. Minimum gap between acceptances is 3+DATA_W*loops+HIT_LAT cycles.
- Hit counting: det_hit is sampled in SHIFT and DRAIN only; each high cycle adds 1. At all-ones the count holds and hit_sat is set. det_hit is ignored in IDLE, LOAD and DONE.
- hit_count holds its value after DONE until the next acceptance.
- abort in LOAD/SHIFT/DRAIN: next state is IDLE, no done, hit_count retained. abort in DONE: done still pulses.
- det_din=0 in every state except SHIFT; det_clr is high only in LOAD.

Decomposition:
- Shared package: state encoding localparams (ST_IDLE..ST_DONE, 3 bits) and the default widths.
- One sub-module, sat_counter (CNT_W, clear, inc → count, sat), reused for hit counting.

Test Plan:
- Stub detector det_hit<=det_din (HIT_LAT=1), in_data=8'h91, in_loops=2, accept at cycle 0 -> det_clr at cycle 1; det_din pattern 1,0,0,0,1,0,0,1 twice over cycles 2..17; done at cycle 19; hit_count=6, hit_sat=0.
- in_loops=0, in_data=8'h01 -> single pass, exactly 8 SHIFT cycles, hit_count=1.
- CNT_W=2, in_data=8'hFF, in_loops=1 -> hit_count=3, hit_sat=1, done pulses once.
- abort asserted at the 4th SHIFT cycle of 8'h91 -> IDLE next cycle, no done, det_din=0, hit_count=1, in_ready=1.
- rst_=0 for one edge mid-SHIFT -> all outputs 0, state IDLE; next word 8'h03 runs cleanly with hit_count=2.
- Real check_sm with HIT_LAT set to its latency, in_data=8'h91 vs 8'h94, in_loops=3 -> hit_count matches a golden software model of the pattern detector.
